fft_out_serializer: RTL and testbench

Parallel-in, serial-out complex output buffer for the 64-point FFT. It accepts one 8-point complex row of butterfly results per handshake and drains it one sample per cycle over a valid/ready stream. It is the egress counterpart to the 8-deep serial input shift register. Two row banks (ping-pong) let the next row load while the current row drains, so the block sustains one sample per cycle with no bubbles.

---
 rtl/fft_out_serializer.sv | 82 ++++++++
 tb/tb_fft_out_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// Ping-pong parallel-in/serial-out buffer for 64-point FFT rows: loads 8 complex samples per
// handshake and drains one per cycle. Define FFT_OUT_BITREV_EN to emit each row in bit-reversed slot order.
module fft_out_serializer #(
    parameter int DW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] din_re,
    input  logic [8*DW-1:0] din_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   dout_re,
    output logic [DW-1:0]   dout_im,
    output logic            out_last
);

    logic [DW-1:0] bank_re [2][8];
    logic [DW-1:0] bank_im [2][8];
    logic          wbank;
    logic          rbank;
    logic [1:0]    fill;
    logic [2:0]    slot;
    logic [2:0]    rd_idx;
    logic          load;
    logic          accept;
    logic          row_done;

`ifdef FFT_OUT_BITREV_EN
    // Undo the DIF bit-reversed ordering so a row leaves in natural order.
    assign rd_idx = {slot[0], slot[1], slot[2]};
`else
    assign rd_idx = slot;
`endif

    assign in_ready  = (fill != 2'd2);
    assign out_valid = (fill != 2'd0);
    assign out_last  = out_valid && (slot == 3'd7);
    assign dout_re   = bank_re[rbank][rd_idx];
    assign dout_im   = bank_im[rbank][rd_idx];

    assign load     = in_valid && in_ready;
    assign accept   = out_valid && out_ready;
    assign row_done = accept && (slot == 3'd7);

    // A load and a row-final accept in the same cycle cancel, which keeps streaming bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            fill  <= 2'd0;
            slot  <= 3'd0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bank_re[b][k] <= '0;
                    bank_im[b][k] <= '0;
                end
            end
        end else begin
            if (load) begin
                for (int k = 0; k < 8; k++) begin
                    bank_re[wbank][k] <= din_re[k*DW +: DW];
                    bank_im[wbank][k] <= din_im[k*DW +: DW];
                end
                wbank <= ~wbank;
            end
            if (accept) begin
                slot <= slot + 3'd1;
                if (slot == 3'd7) begin
                    rbank <= ~rbank;
                end
            end
            case ({load, row_done})
                2'b10:   fill <= fill + 2'd1;
                2'b01:   fill <= fill - 2'd1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed self-checking bench for fft_out_serializer; expectations follow FFT_OUT_BITREV_EN
// so the same bench covers both emission orders.
module tb_fft_out_serializer;

    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [8*DW-1:0] din_re;
    logic [8*DW-1:0] din_im;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   dout_re;
    logic [DW-1:0]   dout_im;
    logic            out_last;

    int tests_run = 0;
    int tests_failed = 0;

    fft_out_serializer #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_re    (din_re),
        .din_im    (din_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic int emit_index(int s);
`ifdef FFT_OUT_BITREV_EN
        logic [2:0] v;
        v = s[2:0];
        return int'({v[0], v[1], v[2]});
`else
        return s;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_re(int base, int s);
        int v;
        v = base + emit_index(s) + 1;
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_im(int base, int s);
        logic [DW-1:0] r;
        r = exp_re(base, s);
        return -r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present row with element k = base+k+1 (real) and its negation (imag), or idle the input.
    task automatic applyStimulus(input logic valid, input int base);
        in_valid = valid;
        for (int k = 0; k < 8; k++) begin
            logic [DW-1:0] v;
            v = DW'(base + k + 1);
            din_re[k*DW +: DW] = v;
            din_im[k*DW +: DW] = -v;
        end
    endtask

    task automatic checkSample(input string tag, input int base, input int s);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_re"},    32'(dout_re),   32'(exp_re(base, s)));
        checkOutput({tag, "_im"},    32'(dout_im),   32'(exp_im(base, s)));
        checkOutput({tag, "_last"},  32'(out_last),  32'(s == 7));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready),  32'd1);
        checkOutput({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    // Drain one row with out_ready high, optionally stalling for n cycles at one slot.
    task automatic drainRow(input string tag, input int base, input int stall_slot, input int stall_n);
        for (int s = 0; s < 8; s++) begin
            checkSample(tag, base, s);
            if (s == stall_slot) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_n; c++) begin
                    tick();
                    checkSample({tag, "_stall"}, base, s);
                end
                out_ready = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 0);
        tick();
        tick();

        checkIdle("reset");
        checkOutput("reset_re", 32'(dout_re), 32'd0);
        checkOutput("reset_im", 32'(dout_im), 32'd0);
        rst = 1'b0;

        // Single row with first sample one cycle after the load edge.
        out_ready = 1'b1;
        applyStimulus(1'b1, 0);
        tick();
        applyStimulus(1'b0, 0);
        drainRow("single", 0, -1, 0);
        checkIdle("single_after");

        // Three-cycle stall at slot 4.
        applyStimulus(1'b1, 10);
        tick();
        applyStimulus(1'b0, 0);
        drainRow("bp", 10, 4, 3);
        checkIdle("bp_after");

        // Fill both banks; a third row must be refused.
        out_ready = 1'b0;
        applyStimulus(1'b1, 20);
        tick();
        checkOutput("fill1_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 30);
        tick();
        checkOutput("fill2_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 40);
        tick();
        tick();
        checkOutput("fill2_hold_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 0);
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            checkSample("rowA", 20, s);
            checkOutput("rowA_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        checkOutput("rowA_done_ready", 32'(in_ready), 32'd1);
        drainRow("rowB", 30, -1, 0);
        checkIdle("rowC_dropped");

        // Load coinciding with the row-final accept keeps the stream contiguous.
        applyStimulus(1'b1, 50);
        tick();
        applyStimulus(1'b0, 0);
        for (int s = 0; s < 8; s++) begin
            checkSample("rowD", 50, s);
            if (s == 7) applyStimulus(1'b1, 60);
            tick();
        end
        applyStimulus(1'b0, 0);
        checkOutput("rowE_ready", 32'(in_ready), 32'd1);
        drainRow("rowE", 60, -1, 0);
        checkIdle("rowE_after");

        // Sixteen rows streamed back to back.
        applyStimulus(1'b1, 100);
        tick();
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < 8; s++) begin
                checkSample("stream", 100 + 8 * r, s);
                if (s == 7 && r < 15) applyStimulus(1'b1, 100 + 8 * (r + 1));
                else applyStimulus(1'b0, 0);
                tick();
            end
        end
        checkIdle("stream_after");

        // Reset mid-drain discards everything.
        applyStimulus(1'b1, 200);
        tick();
        applyStimulus(1'b1, 210);
        tick();
        applyStimulus(1'b0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle("midrst");
        checkOutput("midrst_re", 32'(dout_re), 32'd0);
        checkOutput("midrst_im", 32'(dout_im), 32'd0);
        tick();
        tick();
        checkIdle("midrst_later");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
